// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time IMEM loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [7:0]  DEFAULT_MAGIC = 8'hA5;
  localparam int unsigned LEN_W         = 16;

  typedef struct packed {
    logic rx_ready;
    logic core_rst;
    logic busy;
    logic done;
    logic err;
  } flags_t;

  // Status outputs are a pure function of the state being entered.
  function automatic flags_t flags_for(state_t s);
    flags_t f;
    f.rx_ready = (s == ST_SYNC) || (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA);
    f.core_rst = (s != ST_DONE);
    f.busy     = f.rx_ready || (s == ST_WRITE);
    f.done     = (s == ST_DONE);
    f.err      = (s == ST_ERR);
    return f;
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a byte stream into little-endian 32-bit words; word is valid while word_full is high.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        strobe,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [23:0] shreg;
  logic [1:0]  lane;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      shreg <= '0;
      lane  <= '0;
    end else if (strobe) begin
      shreg <= {byte_in, shreg[23:8]};
      lane  <= lane + 2'd1;
    end
  end

  // Fourth byte is merged combinationally so the write can be issued on the accepting edge.
  assign word      = {byte_in, shreg};
  assign word_full = strobe && (lane == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a framed byte stream, writes words into IMEM, releases the core when done.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned MEM_DEPTH_WORDS = 1024,
  parameter logic [7:0]  MAGIC           = DEFAULT_MAGIC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        core_rst,
  output logic        busy,
  output logic        done,
  output logic        err
);

  state_t           state;
  flags_t           flags;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] k;
  logic [LEN_W-1:0] k_next;
  logic [LEN_W-1:0] n_words;
  logic             accept;
  logic             session_start;
  logic [31:0]      pk_word;
  logic             pk_full;

  assign {rx_ready, core_rst, busy, done, err} = flags;

  assign accept        = rx_valid && rx_ready;
  assign session_start = start && !busy;
  assign k_next        = k + LEN_W'(1);
  assign n_words       = {rx_data, len[7:0]};

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (session_start),
    .strobe    (accept && (state == ST_DATA)),
    .byte_in   (rx_data),
    .word      (pk_word),
    .word_full (pk_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      flags   <= flags_for(ST_IDLE);
      len     <= '0;
      k       <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state <= ST_SYNC;
            flags <= flags_for(ST_SYNC);
          end
        end
        ST_SYNC: begin
          if (accept) begin
            if (rx_data == MAGIC) begin
              state <= ST_LEN0;
              flags <= flags_for(ST_LEN0);
            end else begin
              state <= ST_ERR;
              flags <= flags_for(ST_ERR);
            end
          end
        end
        ST_LEN0: begin
          if (accept) begin
            len[7:0] <= rx_data;
            state    <= ST_LEN1;
            flags    <= flags_for(ST_LEN1);
          end
        end
        ST_LEN1: begin
          if (accept) begin
            len <= n_words;
            k   <= '0;
            if (n_words == '0) begin
              state <= ST_DONE;
              flags <= flags_for(ST_DONE);
            end else if (32'(n_words) > MEM_DEPTH_WORDS) begin
              state <= ST_ERR;
              flags <= flags_for(ST_ERR);
            end else begin
              state <= ST_DATA;
              flags <= flags_for(ST_DATA);
            end
          end
        end
        ST_DATA: begin
          if (pk_full) begin
            wr_en   <= 1'b1;
            wr_addr <= 32'({k, 2'b00});
            wr_data <= pk_word;
            state   <= ST_WRITE;
            flags   <= flags_for(ST_WRITE);
          end
        end
        ST_WRITE: begin
          k <= k_next;
          if (k_next == len) begin
            state <= ST_DONE;
            flags <= flags_for(ST_DONE);
          end else begin
            state <= ST_DATA;
            flags <= flags_for(ST_DATA);
          end
        end
        default: begin
          state <= ST_IDLE;
          flags <= flags_for(ST_IDLE);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        core_rst;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [31:0] addr_log[$];
  logic [31:0] data_log[$];

  always #5 clk = ~clk;

  imem_loader #(.MEM_DEPTH_WORDS(1024), .MAGIC(8'hA5)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .core_rst (core_rst),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always @(negedge clk) begin
    if (wr_en) begin
      addr_log.push_back(wr_addr);
      data_log.push_back(wr_data);
    end
  end

  // Presents one byte from a negedge and returns on the negedge after it is accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    rx_valid = 1'b0;
    for (int i = 0; i < gap; i++) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: byte %h not accepted within 50 cycles", b);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    addr_log.delete();
    data_log.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL reset_core_rst: got %b expected 1", core_rst); end
    checks++; if ({rx_ready, wr_en, busy, done, err} !== 5'b0) begin errors++;
      $display("FAIL reset_flags: got rdy/we/busy/done/err=%b expected 00000", {rx_ready, wr_en, busy, done, err}); end
    checks++; if (wr_addr !== 32'h0 || wr_data !== 32'h0) begin errors++;
      $display("FAIL reset_wr_bus: got addr=%h data=%h expected 0/0", wr_addr, wr_data); end
  endtask

  task automatic test_two_word();
    logic [7:0] frame [11] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    pulse_start();
    for (int i = 0; i < 11; i++) send_byte(frame[i], 0);
    checks++; if (wr_en !== 1'b1 || wr_addr !== 32'h4) begin errors++;
      $display("FAIL two_word_write_latency: got we=%b addr=%h expected 1/00000004", wr_en, wr_addr); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL two_word_early_done: got %b expected 0", done); end
    @(negedge clk);
    checks++; if ({done, core_rst, wr_en, busy} !== 4'b1000) begin errors++;
      $display("FAIL two_word_release: got done/core_rst/we/busy=%b expected 1000", {done, core_rst, wr_en, busy}); end
    checks++; if (addr_log.size() !== 2) begin errors++; $display("FAIL two_word_count: got %0d expected 2", addr_log.size()); end
    else begin
      checks++; if (addr_log[0] !== 32'h0 || data_log[0] !== 32'h00000013) begin errors++;
        $display("FAIL two_word_w0: got %h:%h expected 00000000:00000013", addr_log[0], data_log[0]); end
      checks++; if (addr_log[1] !== 32'h4 || data_log[1] !== 32'h00100093) begin errors++;
        $display("FAIL two_word_w1: got %h:%h expected 00000004:00100093", addr_log[1], data_log[1]); end
    end
    repeat (3) @(negedge clk);
    checks++; if (addr_log.size() !== 2 || wr_data !== 32'h00100093) begin errors++;
      $display("FAIL two_word_hold: got writes=%0d data=%h expected 2/00100093", addr_log.size(), wr_data); end
  endtask

  task automatic test_bad_magic();
    logic [7:0] frame [7] = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    pulse_start();
    send_byte(8'h5A, 0);
    checks++; if ({err, core_rst, rx_ready, busy} !== 4'b1100) begin errors++;
      $display("FAIL bad_magic_flags: got err/core_rst/rdy/busy=%b expected 1100", {err, core_rst, rx_ready, busy}); end
    pulse_start();
    checks++; if (err !== 1'b0 || busy !== 1'b1) begin errors++;
      $display("FAIL bad_magic_restart: got err=%b busy=%b expected 0/1", err, busy); end
    for (int i = 0; i < 7; i++) send_byte(frame[i], 1);
    @(negedge clk);
    checks++; if (done !== 1'b1 || core_rst !== 1'b0) begin errors++;
      $display("FAIL bad_magic_recover: got done=%b core_rst=%b expected 1/0", done, core_rst); end
    checks++; if (addr_log.size() !== 1 || data_log[0] !== 32'h12345678 || addr_log[0] !== 32'h0) begin errors++;
      $display("FAIL bad_magic_word: got n=%0d data=%h expected 1/12345678", addr_log.size(), wr_data); end
  endtask

  task automatic test_length_bounds();
    pulse_start();
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h04, 0);
    checks++; if (err !== 1'b1 || core_rst !== 1'b1) begin errors++;
      $display("FAIL oversize_err: got err=%b core_rst=%b expected 1/1", err, core_rst); end
    repeat (2) @(negedge clk);
    checks++; if (addr_log.size() !== 0) begin errors++; $display("FAIL oversize_writes: got %0d expected 0", addr_log.size()); end
    pulse_start();
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    checks++; if ({done, core_rst, busy} !== 3'b100) begin errors++;
      $display("FAIL zero_len_done: got done/core_rst/busy=%b expected 100", {done, core_rst, busy}); end
    checks++; if (addr_log.size() !== 0) begin errors++; $display("FAIL zero_len_writes: got %0d expected 0", addr_log.size()); end
    pulse_start();
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h04, 0);
    checks++; if ({err, busy, rx_ready} !== 3'b011) begin errors++;
      $display("FAIL max_len_accept: got err/busy/rdy=%b expected 011", {err, busy, rx_ready}); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({core_rst, busy, rx_ready} !== 3'b100) begin errors++;
      $display("FAIL max_len_abort: got core_rst/busy/rdy=%b expected 100", {core_rst, busy, rx_ready}); end
  endtask

  task automatic test_rst_mid_frame();
    logic [7:0] frame [9] = '{8'hA5, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    int ready_seen;
    pulse_start();
    for (int i = 0; i < 9; i++) send_byte(frame[i], int'($urandom_range(0, 2)));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({core_rst, busy, rx_ready, done, err, wr_en} !== 6'b100000) begin errors++;
      $display("FAIL mid_rst_flags: got core_rst/busy/rdy/done/err/we=%b expected 100000", {core_rst, busy, rx_ready, done, err, wr_en}); end
    ready_seen = 0;
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rx_ready || wr_en || !core_rst) ready_seen++;
    end
    rx_valid = 1'b0;
    checks++; if (ready_seen !== 0) begin errors++; $display("FAIL mid_rst_quiet: got %0d active cycles expected 0", ready_seen); end
    checks++; if (addr_log.size() !== 1) begin errors++; $display("FAIL mid_rst_count: got %0d expected 1", addr_log.size()); end
    else begin
      checks++; if (addr_log[0] !== 32'h0 || data_log[0] !== 32'h44332211) begin errors++;
        $display("FAIL mid_rst_word: got %h:%h expected 00000000:44332211", addr_log[0], data_log[0]); end
    end
  endtask

  task automatic test_reload();
    pulse_start();
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL reload_pre_done: got %b expected 1", done); end
    pulse_start();
    checks++; if ({core_rst, busy, rx_ready, done} !== 4'b1110) begin errors++;
      $display("FAIL reload_restart: got core_rst/busy/rdy/done=%b expected 1110", {core_rst, busy, rx_ready, done}); end
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'hEF, 0); send_byte(8'hBE, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if ({busy, rx_ready, err} !== 3'b110) begin errors++;
      $display("FAIL start_in_data: got busy/rdy/err=%b expected 110", {busy, rx_ready, err}); end
    send_byte(8'hAD, 0); send_byte(8'hDE, 0);
    checks++; if (wr_en !== 1'b1 || wr_data !== 32'hDEADBEEF || wr_addr !== 32'h0) begin errors++;
      $display("FAIL start_in_data_write: got we=%b %h:%h expected 1 00000000:deadbeef", wr_en, wr_addr, wr_data); end
    @(negedge clk);
    checks++; if (done !== 1'b1 || core_rst !== 1'b0 || addr_log.size() !== 1) begin errors++;
      $display("FAIL start_in_data_done: got done=%b core_rst=%b writes=%0d expected 1/0/1", done, core_rst, addr_log.size()); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_two_word();
    test_bad_magic();
    test_length_bounds();
    test_rst_mid_frame();
    test_reload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader for the RV32I single-cycle core. It receives a framed byte stream on a valid/ready interface and packs it into little-endian 32-bit words. It writes those words sequentially into the instruction memory's write port, and holds the core in reset until a complete, valid image has been loaded. It sits between the host/UART receive path and the IMEM write port, and drives the core's reset.

## Interface
Parameters:
- MEM_DEPTH_WORDS, 1024, IMEM capacity in 32-bit words; sets the largest legal image length.
- MAGIC, 8'hA5, required first byte of every frame.

Ports:
- clk  input  1  core clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that opens a load session.
- rx_valid  input  1  byte available on rx_data.
- rx_data  input  8  incoming byte.
- rx_ready  output  1  loader can accept a byte this cycle.
- wr_en  output  1  IMEM write strobe, one cycle per word.
- wr_addr  output  32  IMEM byte address; always 4-byte aligned.
- wr_data  output  32  instruction word to write.
- core_rst  output  1  holds the core in reset while high.
- busy  output  1  a session is in progress.
- done  output  1  image loaded; core released.
- err  output  1  frame rejected.

## Operation
- Frame layout, in order:
  - MAGIC.
  - LEN_LO, then LEN_HI: 16-bit word count N, little-endian.
  - 4·N data bytes, little-endian within each word: the first byte becomes bits [7:0].
- A byte transfers only on a cycle with rx_valid && rx_ready.
- States:
  - IDLE: start → SYNC.
  - SYNC: MAGIC accepted → LEN0; any other byte accepted → ERR.
  - LEN0: capture LEN_LO → LEN1.
  - LEN1: capture LEN_HI, then evaluate N:
    - N == 0 → DONE.
    - N > MEM_DEPTH_WORDS → ERR.
    - otherwise → DATA, with word counter and byte lane both 0.
  - DATA: accepted byte goes into lane 0..3. On lane 3 → WRITE.
  - WRITE: one cycle; wr_en = 1, wr_addr = 4·k, wr_data = the packed word; k increments. If k+1 == N → DONE, else → DATA.
  - DONE: stays until start → SYNC.
  - ERR: stays until start → SYNC.
- Output values per state:
  - rx_ready = 1 only in SYNC, LEN0, LEN1 and DATA.
  - core_rst = 1 in every state except DONE.
  - busy = 1 in SYNC, LEN0, LEN1, DATA and WRITE.
  - done = 1 only in DONE; err = 1 only in ERR.
- start is ignored while busy. A start pulse in DONE re-asserts core_rst the next cycle, so the image can be reloaded.
- wr_addr and wr_data are registered and hold their last value outside WRITE.

## Timing
- Reset values: state IDLE, rx_ready 0, wr_en 0, wr_addr 0, wr_data 0, core_rst 1, busy 0, done 0, err 0. Word counter, byte lane and length are cleared.
- rst has priority over every other input, including a session in mid-frame. After rst the core stays held and no write is issued.
- State changes and all outputs update on the clock edge after the qualifying handshake.
- Write latency: wr_en is high in the cycle immediately after the 4th byte of a word is accepted.
- Throughput: at most 4 words per 5·4 = 20 cycles; DATA stalls for exactly 1 cycle (WRITE) per word.
- Word counter width is 16 bits; wr_addr = {k, 2'b00} zero-extended to 32 bits. Word index k never exceeds MEM_DEPTH_WORDS-1, because oversize N is rejected.
- release timing:
  - core_rst falls the same edge done rises, i.e. one cycle after the final WRITE, or one cycle after LEN_HI when N == 0.
  - No wr_en occurs after done rises.
- Stream gaps: rx_valid low for any number of cycles just pauses the FSM; no timeout.

## Structure
- Package imem_loader_pkg holds:
  - the state encoding (IDLE, SYNC, LEN0, LEN1, DATA, WRITE, DONE, ERR);
  - the default MAGIC;
  - LEN_W = 16.
- Sub-module byte_packer: 4-lane shift register with a lane counter.
  - Inputs: byte and strobe.
  - Outputs: the 32-bit word and a word_full pulse.
  - Cleared on rst and on session start.
- The IMEM write port consumes wr_en, wr_addr and wr_data; it indexes the array by wr_addr[31:2].

## Test plan
- Reset then idle 10 cycles → core_rst = 1; rx_ready, wr_en, busy, done and err all 0.
- start; send A5 02 00 13 00 00 00 93 00 10 00 → two writes:
  - addr 0, data 00000013;
  - addr 4, data 00100093.
  - done = 1 and core_rst = 0 one cycle after the second wr_en.
- start; send 5A → err = 1, core_rst = 1, rx_ready = 0, no wr_en. Then start + a valid 1-word frame → recovers to done.
- start; send A5 01 04 (N = 1025 > 1024) → err, no writes. Separately, A5 00 00 → done with zero writes.
- Valid 3-word frame with rx_valid toggling randomly, and rst pulsed after the 6th data byte → after reset: IDLE, core_rst = 1, only 1 write issued (addr 0), no further writes.
- After done, pulse start → core_rst = 1 next cycle, busy = 1, state SYNC. A start pulse during DATA is ignored and the frame completes normally.
